// File: rtl/downn_fifo_pkg.sv
// downn_fifo_pkg: shared constants and elaboration-time legality helpers
// for the generic-ratio down-width FIFO (downn_fifo) and its lanes.
package downn_fifo_pkg;

    localparam int MIN_RATIO = 2;
    localparam int MAX_RATIO = 16;

    // Bits needed to hold a lane count in the range 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Lane count must stay inside the supported mux range.
    function automatic bit ratio_legal(input int ratio);
        return (ratio >= MIN_RATIO) && (ratio <= MAX_RATIO);
    endfunction

    // Per-lane depth must be a power of two so pointers wrap naturally.
    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Total capacity must split evenly across the lanes.
    function automatic bit size_legal(input int size, input int ratio);
        return (ratio > 0) && (size == ratio * (size / ratio));
    endfunction

endpackage

// File: rtl/downn_fifo_if.sv
// downn_fifo_if: write/read bundle of the down-width FIFO.
// Handshake: a lane push[i] is taken at a rising edge only when full[i] is
// low at that edge (ack[i] reports it one cycle later); pop is taken only
// when empty is low at that edge, and its word appears on rdata with
// valid high one cycle later. Requests against full/empty are dropped.
interface downn_fifo_if #(
    parameter int WIDTH = 16,
    parameter int RATIO = 4
);
    logic [RATIO-1:0]       push;
    logic [RATIO*WIDTH-1:0] wdata;
    logic                   pop;
    logic [WIDTH-1:0]       rdata;
    logic                   valid;
    logic [RATIO-1:0]       ack;
    logic [RATIO-1:0]       full;
    logic [RATIO-1:0]       al_full;
    logic                   empty;
    logic                   al_empty;

    modport master (
        output push, wdata, pop,
        input  rdata, valid, ack, full, al_full, empty, al_empty
    );

    modport slave (
        input  push, wdata, pop,
        output rdata, valid, ack, full, al_full, empty, al_empty
    );
endinterface

// File: rtl/downn_lane.sv
// downn_lane: one single-width FIFO lane. Pointers carry a wrap bit; the
// count drives the full/empty flags. Requests against full/empty are
// ignored, so the caller may present raw push/pop requests.
module downn_lane
    import downn_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              head,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push+pop leaves the count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/downn_fifo.sv
// downn_fifo: down-width FIFO, RATIO lanes written in parallel, read one
// narrow word per cycle from a rotating lane. rd_lane is exported as a
// debug view of the read-lane state. Optional macro DOWNN_FIFO_ERR_EN adds
// sticky overflow/underflow outputs.
module downn_fifo
    import downn_fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int RATIO    = 4,
    parameter int SIZE     = 32,
    parameter int AL_FULL  = 1,
    parameter int AL_EMPTY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    downn_fifo_if.slave                bus,
    output logic [$clog2(RATIO)-1:0]   rd_lane
`ifdef DOWNN_FIFO_ERR_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);
    localparam int DEPTH = SIZE / RATIO;
    localparam int CW    = count_width(DEPTH);
    localparam int LW    = $clog2(RATIO);
    localparam logic [CW-1:0] AL_FULL_C  = CW'(DEPTH - AL_FULL);
    localparam logic [CW-1:0] AL_EMPTY_C = CW'(AL_EMPTY);
    localparam logic [LW-1:0] LAST_LANE  = LW'(RATIO - 1);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("downn_fifo: RATIO outside 2..16");
    end
    if (!size_legal(SIZE, RATIO)) begin : g_bad_size
        $error("downn_fifo: SIZE is not a multiple of RATIO");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("downn_fifo: SIZE/RATIO must be a power of two >= 2");
    end

    logic [WIDTH-1:0] lane_head  [RATIO];
    logic [CW-1:0]    lane_count [RATIO];
    logic [RATIO-1:0] lane_full;
    logic [RATIO-1:0] lane_empty;
    logic [RATIO-1:0] lane_pop;
    logic             rd_empty;
    logic             pop_ok;

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        // Only the lane under the read pointer sees the pop request.
        assign lane_pop[g] = bus.pop && (rd_lane == LW'(g));

        downn_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (bus.push[g]),
            .pop   (lane_pop[g]),
            .wdata (bus.wdata[g*WIDTH +: WIDTH]),
            .head  (lane_head[g]),
            .count (lane_count[g]),
            .full  (lane_full[g]),
            .empty (lane_empty[g])
        );

        assign bus.al_full[g] = (lane_count[g] >= AL_FULL_C);
    end

    assign bus.full     = lane_full;
    assign rd_empty     = lane_empty[rd_lane];
    assign bus.empty    = rd_empty;
    assign bus.al_empty = (lane_count[rd_lane] <= AL_EMPTY_C);
    assign pop_ok       = bus.pop && !rd_empty;

    // Read lane advances after each accepted pop, wrapping by compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_lane <= '0;
        end else if (pop_ok) begin
            rd_lane <= (rd_lane == LAST_LANE) ? '0 : rd_lane + 1'b1;
        end
    end

    // Registered read data/valid and per-lane push acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
            bus.valid <= 1'b0;
            bus.ack   <= '0;
        end else begin
            bus.valid <= pop_ok;
            bus.ack   <= bus.push & ~lane_full;
            if (pop_ok) begin
                bus.rdata <= lane_head[rd_lane];
            end
        end
    end

`ifdef DOWNN_FIFO_ERR_EN
    // Sticky error flags: any dropped lane push, any pop against empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (|(bus.push & lane_full)) overflow  <= 1'b1;
            if (bus.pop && rd_empty)     underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_downn_fifo.sv
// tb_downn_fifo: directed test of downn_fifo with WIDTH=8, RATIO=4,
// SIZE=16 (DEPTH=4), AL_FULL=1, AL_EMPTY=1. Optional DOWNN_FIFO_ERR_EN
// also covers overflow/underflow.
module tb_downn_fifo;
    logic       clk;
    logic       rst_n;
    logic [1:0] rd_lane;
`ifdef DOWNN_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks = 0;
    int errors = 0;

    downn_fifo_if #(.WIDTH(8), .RATIO(4)) bus ();

    downn_fifo #(
        .WIDTH    (8),
        .RATIO    (4),
        .SIZE     (16),
        .AL_FULL  (1),
        .AL_EMPTY (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .rd_lane (rd_lane)
`ifdef DOWNN_FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "/valid"},    bus.valid,    0);
        check({tag, "/rdata"},    bus.rdata,    0);
        check({tag, "/ack"},      bus.ack,      0);
        check({tag, "/full"},     bus.full,     0);
        check({tag, "/al_full"},  bus.al_full,  0);
        check({tag, "/empty"},    bus.empty,    1);
        check({tag, "/al_empty"}, bus.al_empty, 1);
        check({tag, "/rd_lane"},  rd_lane,      0);
`ifdef DOWNN_FIFO_ERR_EN
        check({tag, "/overflow"},  overflow,  0);
        check({tag, "/underflow"}, underflow, 0);
`endif
    endtask

    // Asynchronous reset pulse issued between edges, checked before any edge.
    task automatic do_reset(input string tag);
        bus.push  = '0;
        bus.pop   = 1'b0;
        bus.wdata = '0;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        bus.push  = '0;
        bus.pop   = 1'b0;
        bus.wdata = '0;
        #2;

        // 1. Reset values, ack low after release
        do_reset("reset");
        tick();
        check("post_reset_ack", bus.ack, 0);

        // 2. One full-width push, four pops in lane order
        bus.push  = 4'hF;
        bus.wdata = 32'h44332211;
        tick();
        check("p1_ack",      bus.ack,      4'hF);
        check("p1_empty",    bus.empty,    0);
        check("p1_al_empty", bus.al_empty, 1);
        bus.push = 4'h0;
        bus.pop  = 1'b1;
        tick();
        check("p1_pop0_valid", bus.valid, 1);
        check("p1_pop0_rdata", bus.rdata, 8'h11);
        check("p1_pop0_lane",  rd_lane,   1);
        tick();
        check("p1_pop1_rdata", bus.rdata, 8'h22);
        tick();
        check("p1_pop2_rdata", bus.rdata, 8'h33);
        tick();
        check("p1_pop3_rdata", bus.rdata, 8'h44);
        check("p1_pop3_valid", bus.valid, 1);
        check("p1_pop3_lane",  rd_lane,   0);
        check("p1_pop3_empty", bus.empty, 1);
        bus.pop = 1'b0;
        tick();
        check("p1_idle_valid", bus.valid, 0);
        check("p1_idle_rdata", bus.rdata, 8'h44);

        // 3. Fill all lanes, drop a fifth push, drain in order
        bus.push  = 4'hF;
        bus.wdata = 32'h13121110;
        tick();
        bus.wdata = 32'h23222120;
        tick();
        bus.wdata = 32'h33323130;
        tick();
        check("fill3_al_full", bus.al_full, 4'hF);
        check("fill3_full",    bus.full,    4'h0);
        bus.wdata = 32'h43424140;
        tick();
        check("fill4_full",     bus.full,     4'hF);
        check("fill4_ack",      bus.ack,      4'hF);
        check("fill4_al_empty", bus.al_empty, 0);
        bus.wdata = 32'hEEEEEEEE;
        tick();
        check("over_ack",  bus.ack,  4'h0);
        check("over_full", bus.full, 4'hF);
`ifdef DOWNN_FIFO_ERR_EN
        check("over_flag", overflow, 1);
`endif
        bus.push = 4'h0;
        bus.pop  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                tick();
                check("drain_valid", bus.valid, 1);
                check("drain_rdata", bus.rdata, 32'(k * 16 + l));
            end
        end
        bus.pop = 1'b0;
        check("drain_empty", bus.empty, 1);
        check("drain_lane",  rd_lane,   0);

        // 4. Partial push, third pop hits an empty lane
        bus.push  = 4'b0011;
        bus.wdata = 32'h0000BBAA;
        tick();
        check("part_ack", bus.ack, 4'b0011);
        bus.push = 4'h0;
        bus.pop  = 1'b1;
        tick();
        check("part_pop0_rdata", bus.rdata, 8'hAA);
        tick();
        check("part_pop1_rdata", bus.rdata, 8'hBB);
        check("part_pop1_empty", bus.empty, 1);
        check("part_pop1_lane",  rd_lane,   2);
        tick();
        check("part_rej_valid", bus.valid, 0);
        check("part_rej_lane",  rd_lane,   2);
        check("part_rej_rdata", bus.rdata, 8'hBB);
`ifdef DOWNN_FIFO_ERR_EN
        check("part_underflow", underflow, 1);
        check("part_overflow_sticky", overflow, 1);
`endif
        bus.pop = 1'b0;

        // 5. Full lane 0 with same-cycle push+pop
        do_reset("reset2");
        bus.push = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            bus.wdata = 32'(8'h50 + i);
            tick();
        end
        check("l0_full",    bus.full,    4'b0001);
        check("l0_al_full", bus.al_full, 4'b0001);
        check("l0_ack",     bus.ack,     4'b0001);
        bus.wdata = 32'h00000054;
        bus.pop   = 1'b1;
        tick();
        check("l0_pp_ack",     bus.ack,     4'b0000);
        check("l0_pp_valid",   bus.valid,   1);
        check("l0_pp_rdata",   bus.rdata,   8'h50);
        check("l0_pp_full",    bus.full,    4'b0000);
        check("l0_pp_al_full", bus.al_full, 4'b0001);
        check("l0_pp_lane",    rd_lane,     1);
        bus.push = 4'h0;
        bus.pop  = 1'b0;

        // 6. Reset mid-stream discards contents
        do_reset("reset3");
        bus.push  = 4'hF;
        bus.wdata = 32'h64636261;
        tick();
        bus.wdata = 32'h68676665;
        tick();
        bus.push = 4'h0;
        bus.pop  = 1'b1;
        tick();
        check("mid_pop_rdata", bus.rdata, 8'h61);
        bus.pop = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_values("mid_reset");
        #2;
        rst_n = 1'b1;
        tick();
        // Empty lane: push accepted, same-cycle pop rejected
        bus.push  = 4'b0001;
        bus.wdata = 32'h00000077;
        bus.pop   = 1'b1;
        tick();
        check("new_pp_ack",   bus.ack,   4'b0001);
        check("new_pp_valid", bus.valid, 0);
        check("new_pp_lane",  rd_lane,   0);
        bus.push = 4'h0;
        tick();
        check("new_pop_valid", bus.valid, 1);
        check("new_pop_rdata", bus.rdata, 8'h77);
        check("new_pop_lane",  rd_lane,   1);
        bus.pop = 1'b0;
        tick();
        check("new_idle_valid", bus.valid, 0);
        check("new_idle_rdata", bus.rdata, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
